ps2_note_tracker: RTL and testbench
===================================

Name: ps2_note_tracker

Overview:
- Upstream stage of the tone generator. Consumes the raw PS/2 scan-code byte stream and tracks make/break (F0) and extended (E0) prefixes.
- Keeps a last-note-priority stack of currently held piano keys.
- Presents the half-period count of the most recently pressed, still-held key to the note clock divider.
- Replaces the single-byte keycode compare: correct release handling, typematic-repeat immunity, and fall-back to the previous key when the newest one is released.

Parameters:
- STACK_DEPTH, 4: max simultaneously tracked keys (2..8).
- COUNT_W, 20: width of the half-period count output.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  synchronous, active-low reset.
- scan_byte  in  8  received PS/2 byte.
- scan_valid  in  1  one-cycle strobe; scan_byte is valid this cycle. Back-to-back strobes are legal.
- note_count  out  COUNT_W  half-period count of the top-of-stack key; 0 when the stack is empty.
- note_active  out  1  high when the stack is non-empty.
- held_keys  out  4  number of stack entries.
- note_change  out  1  one-cycle pulse when note_count changes value.

Behaviour:
- Reset: on a clk edge with rst_n=0:
  - parser goes to IDLE; all stack entries and held_keys are cleared.
  - note_count=0, note_active=0, note_change=0.
  - Reset mid-sequence discards any pending F0/E0 prefix.
- Parser FSM advances only on scan_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code -> MAKE action, stay IDLE.
  - BRK: any byte is a break code -> RELEASE action, go to IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is ignored, go to IDLE.
  - EXT_BRK: any byte is ignored, go to IDLE. Extended keys never affect the stack.
  - F0 or E0 received while in BRK/EXT_BRK is treated as the code byte.
- Key table: the stack stores scan codes, not notes. Unmapped codes are ignored for both make and break. Half-period counts (hex):
  - 15:5D2EF 1D:530A8 24:49FB6 2D:45C12 2C:3E47E 35:377C8 3C:316BD
  - 43:2EA85 1C:2EA85 1B:29919 23:25085 2B:22F44 34:1F23E 33:1BBE4 3B:18B76
  - 42:17544 1A:17544 22:14CBA 21:127ED 2A:117D1 32:0F91F 31:0DDF2 3A:0C5AF 41:0BA8B
- MAKE action (mapped code):
  - Code already present: no change (typematic repeat; no reorder).
  - Code absent, not full: push to top; held_keys+1.
  - Code absent, full: discard the oldest (bottom) entry, shift, push to top; held_keys unchanged.
- RELEASE action (mapped code):
  - Code present: remove it, compact the entries above it down one slot; held_keys-1.
  - Code absent: no change.
- Outputs are registered:
  - note_count, note_active and held_keys reflect the stack on the cycle after the strobe that caused the change (latency 1).
  - note_change pulses in that same cycle iff note_count differs from its previous value. Example: releasing a non-top key of a different note gives no pulse; pressing 0x43 while 0x1C is on top gives no pulse.
- At most one stack operation per cycle. No internal stall; every strobe is consumed.

Optional Feature:
- Macro: OCTAVE_SHIFT_EN.
- When defined:
  - Mapped-but-non-piano make codes 0x4E ('-') and 0x55 ('=') decrement/increment an octave register, range -1..+1, saturating. Reset value 0. Their break codes are ignored.
  - note_count = table value << 1 at -1, unchanged at 0, >> 1 at +1 (truncating).
  - The new shift takes effect on the top note with latency 1 and fires note_change if the value changes.
- When undefined: 0x4E and 0x55 are unmapped and ignored; no octave register exists.

Test Plan:
- Reset, then bytes 1C -> note_count=2EA85, note_active=1, held_keys=1, note_change pulse 1 cycle after the strobe. Then F0,1C -> note_count=0, note_active=0, held_keys=0.
- 1C, 23, then F0,23 -> note_count 2EA85 -> 25085 -> 2EA85; held_keys 1,2,1.
- Hold 1C, then repeat byte 1C five times -> held_keys stays 1, no note_change pulses.
- Five makes 15,1D,24,2D,2C with STACK_DEPTH=4 -> held_keys=4, note_count=3E47E; then F0,15 -> no change (15 was evicted).
- E0,1C then E0,F0,1C, then unmapped 76 -> stack remains empty. Then rst_n=0 between F0 and 1C of F0,1C -> the subsequent 1C is treated as a make (note_count=2EA85).
- OCTAVE_SHIFT_EN defined: make 1C, then 55 -> note_count=17542; 55 again -> stays 17542; 4E, 4E -> 5D50A.

Source files
------------

// File: rtl/ps2_note_tracker.sv
// rtl/ps2_note_tracker.sv - PS/2 scan-code parser with a last-note-priority key stack
//
// Purpose:
//   Consumes the raw PS/2 byte stream, decodes make / break (F0) and extended (E0)
//   prefixes, and keeps a stack of currently held piano keys. The half-period count
//   of the newest still-held key is presented to the note clock divider.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   scan_byte    received PS/2 byte
//   scan_valid   one-cycle strobe qualifying scan_byte
//   note_count   half-period count of the top-of-stack key (0 when empty)
//   note_active  stack non-empty
//   held_keys    number of stack entries
//   note_change  one-cycle pulse when note_count changes value
//
// Optional feature macro: OCTAVE_SHIFT_EN
//   When defined, make codes 0x4E ('-') and 0x55 ('=') step a saturating octave
//   register (-1..+1) that scales the presented count.

module ps2_note_tracker #(
    parameter int STACK_DEPTH = 4,
    parameter int COUNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         scan_byte,
    input  logic               scan_valid,
    output logic [COUNT_W-1:0] note_count,
    output logic               note_active,
    output logic [3:0]         held_keys,
    output logic               note_change
);

    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Key table: scan code -> half-period count. Zero means "not a piano key".
    // ------------------------------------------------------------------
    function automatic logic [19:0] half_period(input logic [7:0] code);
        logic [19:0] hp;
        case (code)
            8'h15: hp = 20'h5D2EF;
            8'h1D: hp = 20'h530A8;
            8'h24: hp = 20'h49FB6;
            8'h2D: hp = 20'h45C12;
            8'h2C: hp = 20'h3E47E;
            8'h35: hp = 20'h377C8;
            8'h3C: hp = 20'h316BD;
            8'h43: hp = 20'h2EA85;
            8'h1C: hp = 20'h2EA85;
            8'h1B: hp = 20'h29919;
            8'h23: hp = 20'h25085;
            8'h2B: hp = 20'h22F44;
            8'h34: hp = 20'h1F23E;
            8'h33: hp = 20'h1BBE4;
            8'h3B: hp = 20'h18B76;
            8'h42: hp = 20'h17544;
            8'h1A: hp = 20'h17544;
            8'h22: hp = 20'h14CBA;
            8'h21: hp = 20'h127ED;
            8'h2A: hp = 20'h117D1;
            8'h32: hp = 20'h0F91F;
            8'h31: hp = 20'h0DDF2;
            8'h3A: hp = 20'h0C5AF;
            8'h41: hp = 20'h0BA8B;
            default: hp = 20'h00000;
        endcase
        return hp;
    endfunction

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   make_act;
    logic   rel_act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_byte == BYTE_BRK) begin
                        state_d = ST_BRK;
                    end else if (scan_byte == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT:     state_d = (scan_byte == BYTE_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Extended sequences never produce an action; only plain make/break do.
    always_comb begin
        make_act = 1'b0;
        rel_act  = 1'b0;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: make_act = (scan_byte != BYTE_BRK) && (scan_byte != BYTE_EXT);
                ST_BRK:  rel_act  = 1'b1;
                default: begin
                    make_act = 1'b0;
                    rel_act  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key stack: entry 0 is the oldest key, entry cnt_q-1 is the newest.
    // Slots at or above cnt_q are don't-care and never searched.
    // ------------------------------------------------------------------
    logic [7:0] stk_q [STACK_DEPTH];
    logic [7:0] stk_d [STACK_DEPTH];
    logic [3:0] cnt_q, cnt_d;
    logic       found;
    logic [3:0] fidx;
    logic       is_piano;

    assign is_piano = (half_period(scan_byte) != 20'h00000);

    always_comb begin
        found = 1'b0;
        fidx  = 4'd0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!found && (4'(i) < cnt_q) && (stk_q[i] == scan_byte)) begin
                found = 1'b1;
                fidx  = 4'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stk_d[i] = stk_q[i];
        end
        cnt_d = cnt_q;

        if (make_act && is_piano && !found) begin
            if (cnt_q == 4'(STACK_DEPTH)) begin
                // Full: drop the oldest key, slide everything down, push on top.
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    stk_d[i] = stk_q[i+1];
                end
                stk_d[STACK_DEPTH-1] = scan_byte;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (4'(i) == cnt_q) begin
                        stk_d[i] = scan_byte;
                    end
                end
                cnt_d = cnt_q + 4'd1;
            end
        end else if (rel_act && is_piano && found) begin
            // Compact entries above the released key down by one slot.
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                if (4'(i) >= fidx) begin
                    stk_d[i] = stk_q[i+1];
                end
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (4'(i) == cnt_q - 4'd1) begin
                    stk_d[i] = 8'h00;
                end
            end
            cnt_d = cnt_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Octave register (optional)
    // ------------------------------------------------------------------
`ifdef OCTAVE_SHIFT_EN
    // Two's complement: 2'b11 = -1 (one octave down), 2'b00 = 0, 2'b01 = +1.
    logic [1:0] oct_q, oct_d;

    always_comb begin
        oct_d = oct_q;
        if (make_act && (scan_byte == 8'h4E) && (oct_q != 2'b11)) begin
            oct_d = oct_q - 2'd1;
        end else if (make_act && (scan_byte == 8'h55) && (oct_q != 2'b01)) begin
            oct_d = oct_q + 2'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next output value derived from the next stack state, so the registered
    // outputs track the stack with one cycle of latency.
    // ------------------------------------------------------------------
    logic [7:0]         top_code;
    logic [COUNT_W-1:0] base_count;
    logic [COUNT_W-1:0] note_d;

    always_comb begin
        top_code = 8'h00;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            // cnt_d == 0 wraps to 4'hF and selects nothing.
            if (4'(i) == cnt_d - 4'd1) begin
                top_code = stk_d[i];
            end
        end
    end

    always_comb begin
        base_count = COUNT_W'(half_period(top_code));
        note_d     = base_count;
        if (cnt_d == 4'd0) begin
            note_d = '0;
        end
`ifdef OCTAVE_SHIFT_EN
        else if (oct_d == 2'b11) begin
            note_d = base_count << 1;
        end else if (oct_d == 2'b01) begin
            note_d = base_count >> 1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [COUNT_W-1:0] note_count_q;
    logic               note_active_q;
    logic               note_change_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= 8'h00;
            end
            cnt_q         <= 4'd0;
            note_count_q  <= '0;
            note_active_q <= 1'b0;
            note_change_q <= 1'b0;
`ifdef OCTAVE_SHIFT_EN
            oct_q         <= 2'b00;
`endif
        end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= stk_d[i];
            end
            cnt_q         <= cnt_d;
            note_count_q  <= note_d;
            note_active_q <= (cnt_d != 4'd0);
            note_change_q <= (note_d != note_count_q);
`ifdef OCTAVE_SHIFT_EN
            oct_q         <= oct_d;
`endif
        end
    end

    assign note_count  = note_count_q;
    assign note_active = note_active_q;
    assign held_keys   = cnt_q;
    assign note_change = note_change_q;

endmodule

// File: tb/tb_ps2_note_tracker.sv
// tb/tb_ps2_note_tracker.sv - self-checking bench for ps2_note_tracker
module tb_ps2_note_tracker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_valid = 1'b0;
    logic [7:0]  scan_byte = 8'h00;
    logic [19:0] note_count;
    logic        note_active;
    logic [3:0]  held_keys;
    logic        note_change;

    ps2_note_tracker #(.STACK_DEPTH(DEPTH), .COUNT_W(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_byte  (scan_byte),
        .scan_valid (scan_valid),
        .note_count (note_count),
        .note_active(note_active),
        .held_keys  (held_keys),
        .note_change(note_change)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] KEYS [24] = '{
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
        8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41};
    localparam int HP [24] = '{
        'h5D2EF, 'h530A8, 'h49FB6, 'h45C12, 'h3E47E, 'h377C8, 'h316BD, 'h2EA85,
        'h2EA85, 'h29919, 'h25085, 'h22F44, 'h1F23E, 'h1BBE4, 'h18B76, 'h17544,
        'h17544, 'h14CBA, 'h127ED, 'h117D1, 'h0F91F, 'h0DDF2, 'h0C5AF, 'h0BA8B};

    int checks = 0;
    int failures = 0;

    // Reference model: queue of held codes (back = newest), pending prefix, octave.
    int         note_tab [256];
    logic [7:0] m_stack [$];
    int         m_pre = 0;     // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    int         m_oct = 0;
    int         exp_count = 0;
    bit         exp_change = 1'b0;
    bit         chk_en = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int model_note();
        int v;
        if (m_stack.size() == 0) return 0;
        v = note_tab[m_stack[m_stack.size()-1]];
        if (m_oct < 0) v = v * 2;
        else if (m_oct > 0) v = v / 2;
        return v;
    endfunction

    function automatic int find_key(input logic [7:0] b);
        foreach (m_stack[i]) if (m_stack[i] == b) return i;
        return -1;
    endfunction

    function automatic void key_make(input logic [7:0] b);
`ifdef OCTAVE_SHIFT_EN
        if (b == 8'h4E) begin
            if (m_oct > -1) m_oct--;
            return;
        end
        if (b == 8'h55) begin
            if (m_oct < 1) m_oct++;
            return;
        end
`endif
        if (note_tab[b] == 0) return;
        if (find_key(b) >= 0) return;
        if (m_stack.size() == DEPTH) void'(m_stack.pop_front());
        m_stack.push_back(b);
    endfunction

    function automatic void key_break(input logic [7:0] b);
        int idx;
        if (note_tab[b] == 0) return;
        idx = find_key(b);
        if (idx >= 0) m_stack.delete(idx);
    endfunction

    function automatic void model_step(input bit r, input bit v, input logic [7:0] b);
        int old;
        old = exp_count;
        if (!r) begin
            m_stack.delete();
            m_pre = 0;
            m_oct = 0;
            exp_count = 0;
            exp_change = 1'b0;
            return;
        end
        if (v) begin
            case (m_pre)
                0: begin
                    if (b == 8'hF0) m_pre = 1;
                    else if (b == 8'hE0) m_pre = 2;
                    else key_make(b);
                end
                1: begin
                    key_break(b);
                    m_pre = 0;
                end
                2: m_pre = (b == 8'hF0) ? 3 : 0;
                default: m_pre = 0;
            endcase
        end
        exp_count = model_note();
        exp_change = (exp_count != old);
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("note_count", int'(note_count), exp_count);
            chk("note_active", int'(note_active), int'(m_stack.size() != 0));
            chk("held_keys", int'(held_keys), m_stack.size());
            chk("note_change", int'(note_change), int'(exp_change));
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [7:0] b);
        rst_n = r;
        scan_valid = v;
        scan_byte = b;
        @(posedge clk);
        model_step(r, v, b);
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, 1'b1, b);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
    endtask

    int pulses;
    int k;
    bit r;
    bit v;
    logic [7:0] b;

    initial begin
        for (int i = 0; i < 256; i++) note_tab[i] = 0;
        for (int i = 0; i < 24; i++) note_tab[KEYS[i]] = HP[i];

        @(negedge clk);
        do_reset();
        chk("rst_count", int'(note_count), 0);
        chk("rst_held", int'(held_keys), 0);

        // Single press and release
        send(8'h1C);
        chk("t1_count", int'(note_count), 'h2EA85);
        chk("t1_active", int'(note_active), 1);
        chk("t1_held", int'(held_keys), 1);
        chk("t1_pulse", int'(note_change), 1);
        idle();
        chk("t1_pulse_end", int'(note_change), 0);
        send(8'hF0); send(8'h1C);
        chk("t1_rel_count", int'(note_count), 0);
        chk("t1_rel_active", int'(note_active), 0);

        // Last-note priority and fall-back
        send(8'h1C); send(8'h23);
        chk("t2_count", int'(note_count), 'h25085);
        chk("t2_held", int'(held_keys), 2);
        send(8'hF0); send(8'h23);
        chk("t2_fall_count", int'(note_count), 'h2EA85);
        chk("t2_fall_held", int'(held_keys), 1);
        send(8'h43);
        chk("t2_same_note_pulse", int'(note_change), 0);
        send(8'hF0); send(8'h43);
        send(8'hF0); send(8'h1C);

        // Typematic repeat
        send(8'h1C);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'h1C);
            pulses += int'(note_change);
        end
        chk("t3_pulses", pulses, 0);
        chk("t3_held", int'(held_keys), 1);
        send(8'hF0); send(8'h1C);

        // Overflow evicts the oldest key
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        chk("t4_held", int'(held_keys), 4);
        chk("t4_count", int'(note_count), 'h3E47E);
        send(8'hF0); send(8'h15);
        chk("t4_evicted_held", int'(held_keys), 4);
        chk("t4_evicted_count", int'(note_count), 'h3E47E);
        do_reset();

        // Extended and unmapped codes, reset discarding a pending prefix
        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h1C);
        send(8'h76);
        chk("t5_held", int'(held_keys), 0);
        chk("t5_active", int'(note_active), 0);
        send(8'hF0);
        do_reset();
        send(8'h1C);
        chk("t5_rst_prefix", int'(note_count), 'h2EA85);

`ifdef OCTAVE_SHIFT_EN
        do_reset();
        send(8'h1C);
        send(8'h55);
        chk("t6_up", int'(note_count), 'h17542);
        send(8'h55);
        chk("t6_up_sat", int'(note_count), 'h17542);
        send(8'h4E); send(8'h4E);
        chk("t6_down", int'(note_count), 'h5D50A);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 9) < 7);
            k = $urandom_range(0, 35);
            if (k < 24) b = KEYS[k];
            else if (k < 30) b = 8'hF0;
            else if (k < 32) b = 8'hE0;
            else if (k == 32) b = 8'h76;
            else if (k == 33) b = 8'h4E;
            else if (k == 34) b = 8'h55;
            else b = 8'($urandom_range(0, 255));
            cyc(r, v, b);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
